srff_counter_ctrl: RTL and testbench
====================================

Name: srff_counter_ctrl

Overview:
- Controller and sequencer for an N-bit counter built from SR flip-flops.
- Accepts start/stop/pause commands, loads a start value, and counts up or down one step per tick toward a terminal count.
- Generates per-bit S/R excitation and holds the SR register bank, so q follows SR semantics exactly: q_next = S | (~R & q).
- Sits between the timing/sequence logic and the SR counter datapath; replaces ad-hoc hard-wired SR down counters.

Parameters:
WIDTH, 4, counter width in bits (>=2)
PRESCALE, 4, internal tick divider; used only with SRCTRL_PRESCALE_EN (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin run; sampled in IDLE only
stop  input  1  abort run; highest priority command
pause  input  1  level; hold count while high (RUN/HOLD only)
dir  input  1  0=up, 1=down; latched at start
auto_reload  input  1  reload at terminal instead of finishing; latched at start
load_val  input  WIDTH  start value; latched at start
tick  input  1  count enable strobe
q  output  WIDTH  SR-bank counter value
s_out  output  WIDTH  set excitation applied this cycle (combinational)
r_out  output  WIDTH  reset excitation applied this cycle (combinational)
busy  output  1  high in LOAD, RUN, HOLD
tc  output  1  q == terminal while in RUN/HOLD (combinational)
done  output  1  registered one-cycle pulse at terminal step

Behaviour:
- Reset (async): state=IDLE; q=0; shadow load/dir/reload=0; done=0; busy=0; s_out=r_out=0.
- Terminal value: 0 when dir=1; all-ones when dir=0.
- States:
  - IDLE:
    - q holds; S=R=0.
    - start & ~stop -> LOAD; latch load_val, dir, auto_reload into shadows.
    - start & stop -> stay IDLE.
  - LOAD (exactly 1 cycle):
    - S = shadow & ~q; R = ~shadow & q.
    - q = load value on exit -> RUN.
  - RUN:
    - stop -> IDLE, q holds.
    - else pause -> HOLD.
    - else tick & ~tc -> q steps ±1 via S/R.
    - else tick & tc -> done=1 next cycle.
      - auto_reload=1: q <= shadow via S/R; stay RUN.
      - auto_reload=0: q holds; -> IDLE.
    - No tick -> S=R=0.
  - HOLD:
    - S=R=0.
    - stop -> IDLE.
    - ~pause -> RUN; no step on the release cycle.
- Excitation:
  - target = next q; S = target & ~q; R = ~target & q.
  - S & R must never be nonzero in any bit.
- Count steps never wrap: arithmetic is WIDTH bits, and the terminal check precedes the step.
- load_val equal to terminal: tc is high on the first RUN cycle; the first tick ends or reloads the run.
- Ignored inputs:
  - start outside IDLE.
  - pause in IDLE/LOAD.
  - dir, load_val and auto_reload changes after LOAD.
- Reset asserted mid-run: immediate return to reset values; no done pulse.

Optional Feature:
- Macro SRCTRL_PRESCALE_EN.
- Defined:
  - tick input ignored.
  - Internal divider counts 0..PRESCALE-1 while in RUN and produces the step strobe at PRESCALE-1.
  - Divider cleared in IDLE/LOAD; held in HOLD.
  - PRESCALE=1 means a step every RUN cycle.
- Undefined: tick input used directly; PRESCALE unused; no divider logic.

Test Plan (WIDTH=4, tick held 1 unless stated):
1. Down count: load_val=3, dir=1, auto_reload=0, start pulse.
   - Required: LOAD, then q=3,2,1,0 on successive cycles.
   - Next tick: done pulse 1 cycle, IDLE, q stays 0, busy=0.
2. Up with reload: load_val=13, dir=0, auto_reload=1.
   - Required: q=13,14,15,13,14,15...
   - done pulses the cycle after each 15->13 reload; busy stays 1.
3. Pause/stop: in case-1 style run from 9, raise pause when q=5.
   - Required: q holds 5 for 4 cycles.
   - Release: no step on the release cycle, then 4.
   - stop at q=3: IDLE, q=3.
4. Excitation: q=4'b0110, dir=1, tick.
   - Required: s_out=0001, r_out=0010, q=0101.
   - Assert s_out&r_out==0 every cycle of all tests.
5. Command corners:
   - start&stop together in IDLE: stays IDLE.
   - reset asserted mid-RUN at q=7: q=0 immediately, no done.
   - load_val=0 with dir=1: done on first tick.
6. With SRCTRL_PRESCALE_EN, PRESCALE=4: load_val=2, dir=1.
   - Required: q steps every 4th RUN cycle; done after 3rd step.

Source files
------------

// File: rtl/srff_counter_ctrl_if.sv
// srff_counter_ctrl_if
// Command, configuration and status bundle for the SR-flip-flop counter
// controller.
//   master : the sequencer side. It drives the commands and configuration
//            and observes the counter.
//   slave  : the controller side (srff_counter_ctrl).
// Signals:
//   start, stop, pause, tick      command and strobe inputs to the controller
//   dir, auto_reload, load_val    run configuration, captured at start
//   q, s_out, r_out               SR bank value and its per-bit excitation
//   busy, tc, done                run status
interface srff_counter_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             pause;
   logic             dir;
   logic             auto_reload;
   logic [WIDTH-1:0] load_val;
   logic             tick;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] s_out;
   logic [WIDTH-1:0] r_out;
   logic             busy;
   logic             tc;
   logic             done;

   modport master (
      output start, stop, pause, dir, auto_reload, load_val, tick,
      input  q, s_out, r_out, busy, tc, done
   );

   modport slave (
      input  start, stop, pause, dir, auto_reload, load_val, tick,
      output q, s_out, r_out, busy, tc, done
   );
endinterface

// File: rtl/srff_counter_ctrl.sv
// srff_counter_ctrl
// Sequencer for an N-bit counter that is held in a bank of SR flip-flops.
// The controller accepts start/stop/pause commands and loads a start value.
// It then counts up or down, one step per strobe, toward a terminal count:
// all ones when counting up, zero when counting down. It computes the
// per-bit S/R excitation itself. The bank then updates as
// q_next = S | (~R & q).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    srff_counter_ctrl_if.slave (commands in, counter and status out)
// Parameters:
//   WIDTH     counter width in bits (>= 2)
//   PRESCALE  internal step divider (>= 1). It is used only when the macro
//             SRCTRL_PRESCALE_EN is defined. With the macro undefined, the
//             tick input is the step strobe.
module srff_counter_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   srff_counter_ctrl_if.slave bus
);
   // Stop elaboration on a bad configuration. This check also covers
   // PRESCALE in builds that do not use the divider.
   if (WIDTH < 2 || PRESCALE < 1) begin : g_bad_cfg
      $error("srff_counter_ctrl: WIDTH must be >= 2 and PRESCALE >= 1");
   end

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] shadow_val_reg;
   logic             shadow_dir_reg;
   logic             shadow_reload_reg;
   logic             busy_reg;
   logic             done_reg;

   logic             step;
   logic             run_step;
   logic             tc;
   logic [WIDTH-1:0] terminal;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] s_exc;
   logic [WIDTH-1:0] r_exc;

`ifdef SRCTRL_PRESCALE_EN
   localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [DIV_W-1:0] div_reg;
   // With PRESCALE=1, div_reg stays at 0, so every RUN cycle is a step.
   assign step = (div_reg == DIV_W'(PRESCALE - 1));
`else
   assign step = bus.tick;
`endif

   always_comb begin
      terminal = {WIDTH{~shadow_dir_reg}};
      tc       = ((state_reg == RUN) || (state_reg == HOLD)) && (q_reg == terminal);
      // stop and pause both take priority over a step in the same cycle.
      run_step = (state_reg == RUN) && !bus.stop && !bus.pause && step;
      target   = q_reg;
      case (state_reg)
         LOAD: target = shadow_val_reg;
         RUN: begin
            if (run_step) begin
               // Check for the terminal count before stepping, so the
               // counter never wraps.
               if (!tc) begin
                  target = shadow_dir_reg ? q_reg - WIDTH'(1) : q_reg + WIDTH'(1);
               end else if (shadow_reload_reg) begin
                  target = shadow_val_reg;
               end
            end
         end
         default: target = q_reg;
      endcase
      // A bit is set only where it rises and cleared only where it falls,
      // so S and R are never both active on the same bit.
      s_exc = target & ~q_reg;
      r_exc = ~target & q_reg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg         <= IDLE;
         q_reg             <= '0;
         shadow_val_reg    <= '0;
         shadow_dir_reg    <= 1'b0;
         shadow_reload_reg <= 1'b0;
         busy_reg          <= 1'b0;
         done_reg          <= 1'b0;
`ifdef SRCTRL_PRESCALE_EN
         div_reg           <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         // SR flip-flop update of the counter bank.
         q_reg    <= s_exc | (~r_exc & q_reg);
         case (state_reg)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  state_reg         <= LOAD;
                  busy_reg          <= 1'b1;
                  shadow_val_reg    <= bus.load_val;
                  shadow_dir_reg    <= bus.dir;
                  shadow_reload_reg <= bus.auto_reload;
               end
            end
            LOAD: state_reg <= RUN;
            RUN: begin
               if (bus.stop) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (bus.pause) begin
                  state_reg <= HOLD;
               end else if (step && tc) begin
                  done_reg <= 1'b1;
                  if (!shadow_reload_reg) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (bus.stop) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (!bus.pause) begin
                  state_reg <= RUN;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
`ifdef SRCTRL_PRESCALE_EN
         // The divider advances only on RUN cycles that are not being
         // stopped or paused. It holds in HOLD and clears everywhere else.
         if (state_reg == RUN) begin
            if (!bus.stop && !bus.pause) begin
               div_reg <= step ? '0 : div_reg + DIV_W'(1);
            end
         end else if (state_reg != HOLD) begin
            div_reg <= '0;
         end
`endif
      end
   end

   assign bus.q     = q_reg;
   assign bus.s_out = s_exc;
   assign bus.r_out = r_exc;
   assign bus.busy  = busy_reg;
   assign bus.tc    = tc;
   assign bus.done  = done_reg;
endmodule

// File: tb/tb_srff_counter_ctrl.sv
// tb_srff_counter_ctrl
// Directed-vector scoreboard bench for srff_counter_ctrl with WIDTH=4.
// Each stimulus cycle pushes its hand-computed expected outputs into a
// queue. A monitor on the falling edge pops one entry per cycle and compares
// it with the DUT outputs. The monitor also requires s_out & r_out == 0.
module tb_srff_counter_ctrl;
   logic clk;
   logic reset;

   srff_counter_ctrl_if #(.WIDTH(4)) bus ();

   srff_counter_ctrl #(.WIDTH(4), .PRESCALE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] q;
      logic       busy;
      logic       done;
      logic       tc;
      logic [3:0] s;
      logic [3:0] r;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         vectors++;
         if (bus.q !== e.q || bus.busy !== e.busy || bus.done !== e.done ||
             bus.tc !== e.tc || bus.s_out !== e.s || bus.r_out !== e.r ||
             (bus.s_out & bus.r_out) !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s: got q=%b busy=%b done=%b tc=%b s=%b r=%b, want q=%b busy=%b done=%b tc=%b s=%b r=%b",
                     e.tag, bus.q, bus.busy, bus.done, bus.tc, bus.s_out, bus.r_out,
                     e.q, e.busy, e.done, e.tc, e.s, e.r);
         end else begin
            $display("vec %0d %s ok q=%b busy=%b done=%b tc=%b s=%b r=%b",
                     vectors, e.tag, bus.q, bus.busy, bus.done, bus.tc, bus.s_out, bus.r_out);
         end
      end
   end

   task automatic cfg(input logic [3:0] lv, input logic d, input logic ar);
      bus.load_val    = lv;
      bus.dir         = d;
      bus.auto_reload = ar;
   endtask

   // Apply one cycle of inputs just after the rising edge, and queue the
   // outputs expected in that same cycle.
   task automatic cyc(input logic rs, input logic st, input logic sp, input logic pa,
                      input logic tk, input logic [3:0] eq, input logic eb,
                      input logic ed, input logic etc, input logic [3:0] es,
                      input logic [3:0] er, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rs;
      bus.start = st;
      bus.stop  = sp;
      bus.pause = pa;
      bus.tick  = tk;
      e.q = eq; e.busy = eb; e.done = ed; e.tc = etc; e.s = es; e.r = er; e.tag = tag;
      exp_q.push_back(e);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.pause   = 1'b0;
      bus.tick    = 1'b0;
      cfg(4'd0, 1'b0, 1'b0);

      //   rs st sp pa tk   q  busy done tc   s        r
      cyc(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'b0000, 4'b0000, "reset");

`ifdef SRCTRL_PRESCALE_EN
      // The step strobe comes from the divider, one step every 4 RUN cycles.
      // tick is held low to show it is ignored.
      cfg(4'd2, 1'b1, 1'b0);
      cyc(0, 1, 0, 0, 0, 4'd0, 0, 0, 0, 4'b0000, 4'b0000, "p_start");
      cyc(0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 4'b0010, 4'b0000, "p_load");
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 4'd2, 1, 0, 0, 4'b0000, 4'b0000, "p_wait2");
      cyc(0, 0, 0, 0, 0, 4'd2, 1, 0, 0, 4'b0001, 4'b0010, "p_step1");
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 4'd1, 1, 0, 0, 4'b0000, 4'b0000, "p_wait1");
      cyc(0, 0, 0, 0, 0, 4'd1, 1, 0, 0, 4'b0000, 4'b0001, "p_step2");
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 4'd0, 1, 0, 1, 4'b0000, 4'b0000, "p_wait0");
      cyc(0, 0, 0, 0, 0, 4'd0, 1, 0, 1, 4'b0000, 4'b0000, "p_step3");
      cyc(0, 0, 0, 0, 0, 4'd0, 0, 1, 0, 4'b0000, 4'b0000, "p_done");
      cyc(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'b0000, 4'b0000, "p_idle");
`else
      // 1. Count down from 3 and finish.
      cfg(4'd3, 1'b1, 1'b0);
      cyc(0, 1, 0, 0, 1, 4'd0, 0, 0, 0, 4'b0000, 4'b0000, "t1_start");
      cyc(0, 0, 0, 0, 1, 4'd0, 1, 0, 0, 4'b0011, 4'b0000, "t1_load");
      cyc(0, 0, 0, 0, 1, 4'd3, 1, 0, 0, 4'b0000, 4'b0001, "t1_q3");
      cyc(0, 0, 0, 0, 1, 4'd2, 1, 0, 0, 4'b0001, 4'b0010, "t1_q2");
      cyc(0, 0, 0, 0, 1, 4'd1, 1, 0, 0, 4'b0000, 4'b0001, "t1_q1");
      cyc(0, 0, 0, 0, 1, 4'd0, 1, 0, 1, 4'b0000, 4'b0000, "t1_term");
      cyc(0, 0, 0, 0, 1, 4'd0, 0, 1, 0, 4'b0000, 4'b0000, "t1_done");
      cyc(0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 4'b0000, 4'b0000, "t1_idle");

      // 2. Count up with reload from 13. Config changes after LOAD are ignored.
      cfg(4'd13, 1'b0, 1'b1);
      cyc(0, 1, 0, 0, 1, 4'd0,  0, 0, 0, 4'b0000, 4'b0000, "t2_start");
      cyc(0, 0, 0, 0, 1, 4'd0,  1, 0, 0, 4'b1101, 4'b0000, "t2_load");
      cyc(0, 0, 0, 0, 1, 4'd13, 1, 0, 0, 4'b0010, 4'b0001, "t2_q13");
      cfg(4'd0, 1'b1, 1'b0);
      cyc(0, 0, 0, 0, 1, 4'd14, 1, 0, 0, 4'b0001, 4'b0000, "t2_q14");
      cyc(0, 0, 0, 0, 1, 4'd15, 1, 0, 1, 4'b0000, 4'b0010, "t2_q15");
      cyc(0, 0, 0, 0, 1, 4'd13, 1, 1, 0, 4'b0010, 4'b0001, "t2_reload1");
      cyc(0, 0, 0, 0, 1, 4'd14, 1, 0, 0, 4'b0001, 4'b0000, "t2_q14b");
      cyc(0, 0, 0, 0, 1, 4'd15, 1, 0, 1, 4'b0000, 4'b0010, "t2_q15b");
      cyc(0, 0, 0, 0, 1, 4'd13, 1, 1, 0, 4'b0010, 4'b0001, "t2_reload2");
      cyc(0, 0, 1, 0, 1, 4'd14, 1, 0, 0, 4'b0000, 4'b0000, "t2_stop");
      cyc(0, 0, 0, 0, 1, 4'd14, 0, 0, 0, 4'b0000, 4'b0000, "t2_idle");

      // 3. Pause at 5 for 4 cycles, release, then stop at 3.
      cfg(4'd9, 1'b1, 1'b0);
      cyc(0, 1, 0, 0, 1, 4'd14, 0, 0, 0, 4'b0000, 4'b0000, "t3_start");
      cyc(0, 0, 0, 0, 1, 4'd14, 1, 0, 0, 4'b0001, 4'b0110, "t3_load");
      cyc(0, 0, 0, 0, 1, 4'd9,  1, 0, 0, 4'b0000, 4'b0001, "t3_q9");
      cyc(0, 0, 0, 0, 1, 4'd8,  1, 0, 0, 4'b0111, 4'b1000, "t3_q8");
      cyc(0, 0, 0, 0, 1, 4'd7,  1, 0, 0, 4'b0000, 4'b0001, "t3_q7");
      cyc(0, 0, 0, 0, 1, 4'd6,  1, 0, 0, 4'b0001, 4'b0010, "t3_q6");
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 4'd5, 1, 0, 0, 4'b0000, 4'b0000, "t3_pause");
      cyc(0, 0, 0, 0, 1, 4'd5,  1, 0, 0, 4'b0000, 4'b0000, "t3_release");
      cyc(0, 0, 0, 0, 1, 4'd5,  1, 0, 0, 4'b0000, 4'b0001, "t3_q5");
      cyc(0, 0, 0, 0, 1, 4'd4,  1, 0, 0, 4'b0011, 4'b0100, "t3_q4");
      cyc(0, 0, 1, 0, 1, 4'd3,  1, 0, 0, 4'b0000, 4'b0000, "t3_stop");
      cyc(0, 0, 0, 0, 1, 4'd3,  0, 0, 0, 4'b0000, 4'b0000, "t3_idle");

      // 4. Excitation check from 0110 counting down, then idle ticks.
      cfg(4'd6, 1'b1, 1'b0);
      cyc(0, 1, 0, 0, 1, 4'd3, 0, 0, 0, 4'b0000, 4'b0000, "t4_start");
      cyc(0, 0, 0, 0, 1, 4'd3, 1, 0, 0, 4'b0100, 4'b0001, "t4_load");
      cyc(0, 0, 0, 0, 1, 4'd6, 1, 0, 0, 4'b0001, 4'b0010, "t4_excite");
      cyc(0, 0, 0, 0, 0, 4'd5, 1, 0, 0, 4'b0000, 4'b0000, "t4_notick");
      cyc(0, 0, 1, 0, 0, 4'd5, 1, 0, 0, 4'b0000, 4'b0000, "t4_stop");
      cyc(0, 0, 0, 0, 0, 4'd5, 0, 0, 0, 4'b0000, 4'b0000, "t4_idle");

      // 5a. start together with stop in IDLE: stay IDLE.
      cfg(4'd7, 1'b1, 1'b0);
      cyc(0, 1, 1, 0, 1, 4'd5, 0, 0, 0, 4'b0000, 4'b0000, "t5_startstop");
      cyc(0, 0, 0, 0, 1, 4'd5, 0, 0, 0, 4'b0000, 4'b0000, "t5_stillidle1");
      cyc(0, 0, 0, 0, 1, 4'd5, 0, 0, 0, 4'b0000, 4'b0000, "t5_stillidle2");

      // 5b. Reset asserted mid-run at q=7.
      cfg(4'd10, 1'b1, 1'b0);
      cyc(0, 1, 0, 0, 1, 4'd5,  0, 0, 0, 4'b0000, 4'b0000, "t5b_start");
      cyc(0, 0, 0, 0, 1, 4'd5,  1, 0, 0, 4'b1010, 4'b0101, "t5b_load");
      cyc(0, 0, 0, 0, 1, 4'd10, 1, 0, 0, 4'b0001, 4'b0010, "t5b_q10");
      cyc(0, 0, 0, 0, 1, 4'd9,  1, 0, 0, 4'b0000, 4'b0001, "t5b_q9");
      cyc(0, 0, 0, 0, 1, 4'd8,  1, 0, 0, 4'b0111, 4'b1000, "t5b_q8");
      cyc(1, 0, 0, 0, 1, 4'd0,  0, 0, 0, 4'b0000, 4'b0000, "t5b_reset");
      cyc(0, 0, 0, 0, 1, 4'd0,  0, 0, 0, 4'b0000, 4'b0000, "t5b_nodone1");
      cyc(0, 0, 0, 0, 1, 4'd0,  0, 0, 0, 4'b0000, 4'b0000, "t5b_nodone2");

      // 5c. load_val equal to the terminal value: done on the first tick.
      cfg(4'd0, 1'b1, 1'b0);
      cyc(0, 1, 0, 0, 1, 4'd0, 0, 0, 0, 4'b0000, 4'b0000, "t5c_start");
      cyc(0, 0, 0, 0, 1, 4'd0, 1, 0, 0, 4'b0000, 4'b0000, "t5c_load");
      cyc(0, 0, 0, 0, 1, 4'd0, 1, 0, 1, 4'b0000, 4'b0000, "t5c_term");
      cyc(0, 0, 0, 0, 1, 4'd0, 0, 1, 0, 4'b0000, 4'b0000, "t5c_done");
      cyc(0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 4'b0000, 4'b0000, "t5c_idle");
`endif

      // Let the monitor drain the queue, within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
